ocl_reg_bridge: RTL
===================

// Module: ocl_reg_bridge
// PURPOSE
//  Parametrised host-to-tile register bridge: AXI-Lite (OCL) slave with independent,
//  concurrent read and write engines, fanning accesses out to N_TARGETS reg-bus endpoints.
//  Adds DECERR for unmapped targets, read timeout with SLVERR, a programmable broadcast
//  group, and local status/perf registers. Sits at the tile's host port.
// PARAMETERS
//  N_TARGETS   16           reg-bus endpoints; target id = awaddr/araddr[15:8]
//  DATA_W      32           AXI-Lite and reg-bus data width
//  TIMEOUT     1023         max cycles in R_WAIT before SLVERR; >=1
//  BCAST_ID    8'hFF        write target id that selects the broadcast mask
//  TILE_ID     0            returned by local reg 0x04
// PORTS
//  clk             in   1             clock
//  rst             in   1             async active-high reset
//  awvalid/awready in/out 1/1         AXI-Lite AW handshake
//  awaddr          in   16            write address
//  wvalid/wready   in/out 1/1         AXI-Lite W handshake
//  wdata           in   DATA_W        write data (wstrb ignored, full-word writes)
//  bvalid/bready   out/in 1/1         B handshake
//  bresp           out  2             00 OKAY, 11 DECERR
//  arvalid/arready in/out 1/1         AR handshake
//  araddr          in   16            read address
//  rvalid/rready   out/in 1/1         R handshake
//  rdata           out  DATA_W        read data
//  rresp           out  2             00 OKAY, 10 SLVERR, 11 DECERR
//  reg_wvalid      out  N_TARGETS     per-target write strobe
//  reg_waddr       out  8             register offset
//  reg_wdata       out  DATA_W        write data
//  reg_arvalid     out  N_TARGETS     per-target read request (one-hot)
//  reg_araddr      out  8             register offset
//  reg_rvalid      in   N_TARGETS     per-target read response valid
//  reg_rdata       in   N_TARGETS*DATA_W  per-target read data, target i at [i*DATA_W +: DATA_W]
//  cur_cycle       out  64            free-running cycle counter
// BEHAVIOUR
//  Reset (async): all valids/readies 0 then idle values; cur_cycle=0; bcast_mask=all-ones
//   over targets 1..N-1; counters 0. In-flight transactions are dropped, no response.
//  Target 0 is local (never driven on reg bus). Local regs (offset): 0x00 R cur_cycle[31:0],
//   0x01 R cur_cycle[63:32], 0x02 R timeout_cnt, 0x03 R decerr_cnt, 0x04 R TILE_ID,
//   0x05 RW bcast_mask[N_TARGETS-1:0], 0x06 W any value clears timeout_cnt/decerr_cnt.
//   Unlisted local offsets: read 0 OKAY, write ignored OKAY.
//  Write FSM W_IDLE->W_ISSUE->W_RESP:
//   W_IDLE: awready=1 until AW captured, wready=1 until W captured (either order, or same
//    cycle); both captured -> W_ISSUE.
//   W_ISSUE (1 cycle): id<N_TARGETS, id!=0 -> reg_wvalid[id]=1; id==BCAST_ID ->
//    reg_wvalid=bcast_mask (bit0 forced 0); id==0 -> local write; else no strobe,
//    bresp=DECERR, decerr_cnt+1. -> W_RESP.
//   W_RESP: bvalid=1 held until bready, then W_IDLE. AW->B min latency 2 cycles.
//  Read FSM R_IDLE->R_ISSUE->R_WAIT->R_RESP:
//   R_IDLE: arready=1; on arvalid capture araddr -> R_ISSUE.
//   R_ISSUE (1 cycle): id==0 -> rdata=local reg, OKAY, -> R_RESP; id>=N_TARGETS (incl.
//    BCAST_ID) -> rdata=0, DECERR, decerr_cnt+1, -> R_RESP; else reg_arvalid[id]=1 -> R_WAIT.
//   R_WAIT: timer from 0; reg_rvalid[id] -> capture slice, OKAY, -> R_RESP. rvalid of other
//    targets ignored. rvalid same cycle as timer==TIMEOUT: data wins (OKAY). Timer==TIMEOUT
//    without rvalid -> rdata=32'hDEAD_BEEF, SLVERR, timeout_cnt+1, -> R_RESP.
//   R_RESP: rvalid=1, rdata/rresp stable until rready, then R_IDLE.
//  Read and write engines fully independent; simultaneous local read/write of same reg
//   returns pre-write value. Counters saturate at 2^32-1; cur_cycle wraps at 2^64.
// TESTING
//  1. AW at t0, W at t3, id=3 off 0x10 data 0xA5 -> reg_wvalid=0x0008 one cycle, bvalid OKAY.
//  2. Write 0x05=0x0006, write id 0xFF -> reg_wvalid=0x0006 one cycle; then read id 0x20 ->
//     DECERR, rdata 0; read local 0x03 -> 1.
//  3. Read id 5, reg_rvalid[5] after 7 cycles data 0x1234 -> rvalid, rdata 0x1234 OKAY; stray
//     reg_rvalid[4] ignored.
//  4. TIMEOUT=15, read id 2 never answered -> after 15 cycles SLVERR 0xDEADBEEF; 0x02 reads 1;
//     write 0x06 -> reads 0.
//  5. Concurrent: read id 1 pending while write id 2 completes -> B returns before R, both OK.
//  6. Assert rst in R_WAIT and W_RESP -> all valids 0 next edge, FSMs idle, new access works.

Source files
------------

// File: rtl/ocl_reg_bridge.sv
// AXI-Lite (OCL) slave that bridges host register accesses onto N_TARGETS
// reg-bus endpoints. Independent read/write engines, DECERR for unmapped
// targets, read timeout with SLVERR, broadcast writes and local status regs.
module ocl_reg_bridge #(
  parameter int          N_TARGETS = 16,
  parameter int          DATA_W    = 32,
  parameter int          TIMEOUT   = 1023,
  parameter logic [7:0]  BCAST_ID  = 8'hFF,
  parameter logic [31:0] TILE_ID   = 32'd0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [15:0]                   awaddr,
  input  logic                          wvalid,
  output logic                          wready,
  input  logic [DATA_W-1:0]             wdata,
  output logic                          bvalid,
  input  logic                          bready,
  output logic [1:0]                    bresp,
  input  logic                          arvalid,
  output logic                          arready,
  input  logic [15:0]                   araddr,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [DATA_W-1:0]             rdata,
  output logic [1:0]                    rresp,
  output logic [N_TARGETS-1:0]          reg_wvalid,
  output logic [7:0]                    reg_waddr,
  output logic [DATA_W-1:0]             reg_wdata,
  output logic [N_TARGETS-1:0]          reg_arvalid,
  output logic [7:0]                    reg_araddr,
  input  logic [N_TARGETS-1:0]          reg_rvalid,
  input  logic [N_TARGETS*DATA_W-1:0]   reg_rdata,
  output logic [63:0]                   cur_cycle
);

  localparam int                   IDX_W     = $clog2(N_TARGETS);
  localparam int                   TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]        TIMEOUT_T = TW'(TIMEOUT);
  localparam logic [8:0]           N_T9      = 9'(N_TARGETS);
  localparam logic [N_TARGETS-1:0] TGT_ONE   = {{(N_TARGETS-1){1'b0}}, 1'b1};
  localparam logic [1:0]           RESP_OKAY = 2'b00;
  localparam logic [1:0]           RESP_SLV  = 2'b10;
  localparam logic [1:0]           RESP_DEC  = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_t;

  // Saturating add used by the error counters (both engines may bump decerr at once).
  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] n);
    logic [32:0] s;
    s = {1'b0, v} + 33'(n);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // ---------------- local state ----------------
  logic                 r_live;
  logic [63:0]          r_cur_cycle;
  logic [N_TARGETS-1:0] r_bcast_mask;
  logic [31:0]          r_timeout_cnt;
  logic [31:0]          r_decerr_cnt;

  // ---------------- write engine ----------------
  w_state_t             r_w_state, w_w_state_nxt;
  logic                 r_aw_got, r_w_got;
  logic [15:0]          r_waddr;
  logic [DATA_W-1:0]    r_wdata;
  logic [1:0]           r_bresp;
  logic                 w_aw_fire, w_w_fire;
  logic [7:0]           w_wid, w_woff;
  logic                 w_w_unicast, w_w_bcast, w_w_local, w_w_decerr;
  logic                 w_w_local_wr, w_w_decerr_ev;

  assign awready   = r_live && (r_w_state == W_IDLE) && !r_aw_got;
  assign wready    = r_live && (r_w_state == W_IDLE) && !r_w_got;
  assign w_aw_fire = awvalid && awready;
  assign w_w_fire  = wvalid && wready;
  assign bvalid    = (r_w_state == W_RESP);
  assign bresp     = r_bresp;
  assign reg_waddr = r_waddr[7:0];
  assign reg_wdata = r_wdata;

  assign w_wid       = r_waddr[15:8];
  assign w_woff      = r_waddr[7:0];
  assign w_w_unicast = (w_wid != 8'd0) && ({1'b0, w_wid} < N_T9);
  assign w_w_bcast   = !w_w_unicast && (w_wid == BCAST_ID);
  assign w_w_local   = (w_wid == 8'd0);
  assign w_w_decerr  = !w_w_unicast && !w_w_bcast && !w_w_local;
  assign w_w_local_wr  = (r_w_state == W_ISSUE) && w_w_local;
  assign w_w_decerr_ev = (r_w_state == W_ISSUE) && w_w_decerr;

  // Write FSM next state and reg-bus write strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_w_state_nxt = r_w_state;
    reg_wvalid    = '0;
    unique case (r_w_state)
      W_IDLE:  if ((r_aw_got || w_aw_fire) && (r_w_got || w_w_fire)) w_w_state_nxt = W_ISSUE;
      W_ISSUE: begin
        if (w_w_unicast)    reg_wvalid = TGT_ONE << w_wid;
        else if (w_w_bcast) reg_wvalid = r_bcast_mask & ~TGT_ONE;
        w_w_state_nxt = W_RESP;
      end
      W_RESP:  if (bready) w_w_state_nxt = W_IDLE;
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  // Write FSM state, AW/W capture and response code.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: only control state needs a reset value; captured address/data are reset
    // too here because they are few flops and keep reg_waddr/reg_wdata deterministic.
    if (rst) begin
      r_w_state <= W_IDLE;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_w_state <= w_w_state_nxt;
      if (w_aw_fire) begin
        r_aw_got <= 1'b1;
        r_waddr  <= awaddr;
      end
      if (w_w_fire) begin
        r_w_got <= 1'b1;
        r_wdata <= wdata;
      end
      if (r_w_state == W_ISSUE) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
        r_bresp  <= w_w_decerr ? RESP_DEC : RESP_OKAY;
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t             r_r_state, w_r_state_nxt;
  logic [15:0]          r_raddr;
  logic [TW-1:0]        r_timer;
  logic [DATA_W-1:0]    r_rdata;
  logic [1:0]           r_rresp;
  logic                 w_ar_fire;
  logic [7:0]           w_rid, w_roff;
  logic [IDX_W-1:0]     w_rid_idx;
  logic                 w_r_local, w_r_decerr, w_r_remote;
  logic                 w_rsel_valid;
  logic [DATA_W-1:0]    w_rsel_data;
  logic [DATA_W-1:0]    w_local_rdata;
  logic                 w_r_decerr_ev, w_timeout_ev;

  assign arready      = r_live && (r_r_state == R_IDLE);
  assign w_ar_fire    = arvalid && arready;
  assign rvalid       = (r_r_state == R_RESP);
  assign rdata        = r_rdata;
  assign rresp        = r_rresp;
  assign reg_araddr   = r_raddr[7:0];

  assign w_rid        = r_raddr[15:8];
  assign w_roff       = r_raddr[7:0];
  assign w_rid_idx    = w_rid[IDX_W-1:0];
  assign w_r_local    = (w_rid == 8'd0);
  assign w_r_decerr   = ({1'b0, w_rid} >= N_T9);
  assign w_r_remote   = !w_r_local && !w_r_decerr;
  assign w_rsel_valid = reg_rvalid[w_rid_idx];
  assign w_rsel_data  = reg_rdata[w_rid_idx*DATA_W +: DATA_W];
  assign w_r_decerr_ev = (r_r_state == R_ISSUE) && w_r_decerr;
  assign w_timeout_ev  = (r_r_state == R_WAIT) && !w_rsel_valid && (r_timer == TIMEOUT_T);

  // Local register read mux.
  always_comb begin
    w_local_rdata = '0;
    unique case (w_roff)
      8'h00:   w_local_rdata = DATA_W'(r_cur_cycle[31:0]);
      8'h01:   w_local_rdata = DATA_W'(r_cur_cycle[63:32]);
      8'h02:   w_local_rdata = DATA_W'(r_timeout_cnt);
      8'h03:   w_local_rdata = DATA_W'(r_decerr_cnt);
      8'h04:   w_local_rdata = DATA_W'(TILE_ID);
      8'h05:   w_local_rdata = DATA_W'(r_bcast_mask);
      default: w_local_rdata = '0;
    endcase
  end

  // Read FSM next state and one-hot reg-bus read request.
  always_comb begin
    w_r_state_nxt = r_r_state;
    reg_arvalid   = '0;
    unique case (r_r_state)
      R_IDLE:  if (w_ar_fire) w_r_state_nxt = R_ISSUE;
      R_ISSUE: begin
        if (w_r_remote) begin
          reg_arvalid   = TGT_ONE << w_rid_idx;
          w_r_state_nxt = R_WAIT;
        end else begin
          w_r_state_nxt = R_RESP;
        end
      end
      R_WAIT:  if (w_rsel_valid || (r_timer == TIMEOUT_T)) w_r_state_nxt = R_RESP;
      R_RESP:  if (rready) w_r_state_nxt = R_IDLE;
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  // Read FSM state, timer and response capture (data beats timeout on the last cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r_state <= R_IDLE;
      r_raddr   <= '0;
      r_timer   <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_r_state <= w_r_state_nxt;
      if (w_ar_fire) r_raddr <= araddr;
      unique case (r_r_state)
        R_ISSUE: begin
          r_timer <= '0;
          if (w_r_local) begin
            r_rdata <= w_local_rdata;
            r_rresp <= RESP_OKAY;
          end else if (w_r_decerr) begin
            r_rdata <= '0;
            r_rresp <= RESP_DEC;
          end
        end
        R_WAIT: begin
          if (w_rsel_valid) begin
            r_rdata <= w_rsel_data;
            r_rresp <= RESP_OKAY;
          end else if (r_timer == TIMEOUT_T) begin
            r_rdata <= DATA_W'(32'hDEAD_BEEF);
            r_rresp <= RESP_SLV;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Cycle counter, broadcast mask and saturating error counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live        <= 1'b0;
      r_cur_cycle   <= '0;
      r_bcast_mask  <= ~TGT_ONE;
      r_timeout_cnt <= '0;
      r_decerr_cnt  <= '0;
    end else begin
      r_live      <= 1'b1;
      r_cur_cycle <= r_cur_cycle + 64'd1;
      if (w_w_local_wr && (w_woff == 8'h05)) r_bcast_mask <= r_wdata[N_TARGETS-1:0];
      if (w_w_local_wr && (w_woff == 8'h06)) begin
        r_timeout_cnt <= '0;
        r_decerr_cnt  <= '0;
      end else begin
        r_timeout_cnt <= sat_add(r_timeout_cnt, {1'b0, w_timeout_ev});
        r_decerr_cnt  <= sat_add(r_decerr_cnt, 2'(w_w_decerr_ev) + 2'(w_r_decerr_ev));
      end
    end
  end

  assign cur_cycle = r_cur_cycle;

endmodule
